// File: rtl/sm_run_ctrl_if.sv
// rtl/sm_run_ctrl_if.sv - command, core readout and dump bus for sm_run_ctrl
interface sm_run_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [15:0]       cmd_arg;
    logic              cpu_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [31:0]       dump_data;
    logic              halted;
    logic [CNT_W-1:0]  cycle_cnt;

    // master: the controller; slave: host front end plus core readout port
    modport master (
        input  cmd_valid, cmd_op, cmd_arg, reg_data, dump_ready,
        output cmd_ready, cpu_en, reg_addr, dump_valid, dump_addr, dump_data,
               halted, cycle_cnt
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_arg, reg_data, dump_ready,
        input  cmd_ready, cpu_en, reg_addr, dump_valid, dump_addr, dump_data,
               halted, cycle_cnt
    );
endinterface

// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/halt/step/register-dump controller for the schoolMIPS core
module sm_run_ctrl #(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 32,
    parameter int READ_LAT  = 0
) (
    input  logic          clk,
    input  logic          rst_p,
    sm_run_ctrl_if.master bus
);
    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_COUNT - 1);
    localparam logic [2:0]        WAIT_LOAD = 3'(READ_LAT);

    typedef enum logic [2:0] {
        HALTED    = 3'd0,
        RUN       = 3'd1,
        STEP      = 3'd2,
        DUMP_WAIT = 3'd3,
        DUMP_OUT  = 3'd4
    } runState_t;

    runState_t         state, stateNext;
    logic [15:0]       stepCnt, stepCntNext;
    logic [2:0]        waitCnt, waitCntNext;
    logic [ADDR_W-1:0] regAddr, regAddrNext;
    logic              dumpValid, dumpValidNext;
    logic [ADDR_W-1:0] dumpAddr, dumpAddrNext;
    logic [31:0]       dumpData, dumpDataNext;
    logic              cpuEn, cpuEnNext;
    logic [CNT_W-1:0]  cycleCnt;
    logic              cmdReady;
    logic              cmdAccept;

    // Ready depends on state only, so a command can land on the first HALTED cycle.
    assign cmdReady  = (state == HALTED) || (state == RUN);
    assign cmdAccept = bus.cmd_valid && cmdReady;

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state     <= HALTED;
            stepCnt   <= '0;
            waitCnt   <= '0;
            regAddr   <= '0;
            dumpValid <= 1'b0;
            dumpAddr  <= '0;
            dumpData  <= '0;
            cpuEn     <= 1'b0;
            cycleCnt  <= '0;
        end else begin
            state     <= stateNext;
            stepCnt   <= stepCntNext;
            waitCnt   <= waitCntNext;
            regAddr   <= regAddrNext;
            dumpValid <= dumpValidNext;
            dumpAddr  <= dumpAddrNext;
            dumpData  <= dumpDataNext;
            cpuEn     <= cpuEnNext;
            cycleCnt  <= cycleCnt + CNT_W'(cpuEn);
        end
    end

    always_comb begin
        stateNext     = state;
        stepCntNext   = stepCnt;
        waitCntNext   = waitCnt;
        regAddrNext   = regAddr;
        dumpValidNext = dumpValid;
        dumpAddrNext  = dumpAddr;
        dumpDataNext  = dumpData;

        case (state)
            HALTED: begin
                if (cmdAccept) begin
                    case (bus.cmd_op)
                        OP_RUN: stateNext = RUN;
                        OP_STEP: begin
                            if (bus.cmd_arg != 16'd0) begin
                                stepCntNext = bus.cmd_arg;
                                stateNext   = STEP;
                            end
                        end
                        OP_DUMP: begin
                            regAddrNext = '0;
                            waitCntNext = WAIT_LOAD;
                            stateNext   = DUMP_WAIT;
                        end
                        default: stateNext = HALTED;
                    endcase
                end
            end

            RUN: begin
                // Anything but RUN stops the core; the op itself is dropped.
                if (cmdAccept && (bus.cmd_op != OP_RUN)) begin
                    stateNext = HALTED;
                end
            end

            STEP: begin
                if (stepCnt <= 16'd1) begin
                    stepCntNext = 16'd0;
                    stateNext   = HALTED;
                end else begin
                    stepCntNext = stepCnt - 16'd1;
                end
            end

            DUMP_WAIT: begin
                if (waitCnt == 3'd0) begin
                    dumpDataNext  = bus.reg_data;
                    dumpAddrNext  = regAddr;
                    dumpValidNext = 1'b1;
                    stateNext     = DUMP_OUT;
                end else begin
                    waitCntNext = waitCnt - 3'd1;
                end
            end

            DUMP_OUT: begin
                if (bus.dump_ready) begin
                    dumpValidNext = 1'b0;
                    if (dumpAddr == LAST_ADDR) begin
                        regAddrNext = '0;
                        stateNext   = HALTED;
                    end else begin
                        regAddrNext = regAddr + ADDR_W'(1);
                        waitCntNext = WAIT_LOAD;
                        stateNext   = DUMP_WAIT;
                    end
                end
            end

            default: stateNext = HALTED;
        endcase

        cpuEnNext = (stateNext == RUN) || (stateNext == STEP);
    end

    assign bus.cmd_ready  = cmdReady;
    assign bus.cpu_en     = cpuEn;
    assign bus.reg_addr   = regAddr;
    assign bus.dump_valid = dumpValid;
    assign bus.dump_addr  = dumpAddr;
    assign bus.dump_data  = dumpData;
    assign bus.halted     = (state == HALTED);
    assign bus.cycle_cnt  = cycleCnt;
endmodule

// File: doc/sm_run_ctrl.md
# sm_run_ctrl

Run/step/dump controller for the schoolMIPS core. It owns the core's clock-enable and register-readout port (the `clkEnable` / `regAddr` / `regData` path of `sm_top`) and sequences them from a simple command interface. It provides free run, halt, run-exactly-N-cycles, and a full register-file dump streamed out over a valid/ready port. It sits between a host/debug front end (UART bridge, switches, or a testbench) and `sm_top`.

## Interface
Parameters:
- REG_COUNT, 32: number of registers dumped (addresses 0..REG_COUNT-1); range 1..2^ADDR_W.
- ADDR_W, 5: register address width.
- CNT_W, 32: width of the enabled-cycle counter.
- READ_LAT, 0: cycles from a `reg_addr` change to a valid `reg_data`; 0 means combinational, range 0..7.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_p  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 DUMP.
- cmd_arg  in  16  STEP cycle count N; ignored for the other ops.
- cpu_en  out  1  registered; drives core clkEnable.
- reg_addr  out  ADDR_W  register read address to core.
- reg_data  in  32  register read data from core.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word on valid && ready.
- dump_addr  out  ADDR_W  register index of the current dump word.
- dump_data  out  32  captured register value.
- halted  out  1  high in HALTED state only.
- cycle_cnt  out  CNT_W  number of cycles cpu_en has been 1 since reset.

## Operation
- States: HALTED, RUN, STEP, DUMP_WAIT, DUMP_OUT.
- Reset values (rst_p asserted, effective immediately and asynchronously): state HALTED, cpu_en 0, cmd_ready 1, halted 1, reg_addr 0, dump_valid 0, dump_addr 0, dump_data 0, cycle_cnt 0. Reset mid-STEP or mid-DUMP aborts the operation with no further dump words.
- HALTED: cmd_ready=1.
  - HALT: no-op.
  - RUN: go to RUN.
  - STEP with N>0: load down-counter=N, go to STEP. STEP with N=0: accepted, no-op.
  - DUMP: reg_addr=0, wait counter=READ_LAT, go to DUMP_WAIT.
- RUN: cmd_ready=1, cpu_en=1.
  - RUN: no-op.
  - Any other accepted op (HALT, STEP, DUMP): acts as HALT and the op is discarded. Next state HALTED.
- STEP: cmd_ready=0. cpu_en=1 for exactly N cycles, then HALTED.
- DUMP_WAIT: cmd_ready=0, cpu_en=0. When the wait counter reaches 0: capture reg_data into dump_data, set dump_addr=reg_addr and dump_valid=1, go to DUMP_OUT. Otherwise decrement the counter.
- DUMP_OUT: dump_valid, dump_addr and dump_data are held stable until dump_ready.
  - On handshake, if dump_addr==REG_COUNT-1: dump_valid=0, go to HALTED.
  - On handshake otherwise: reg_addr+1, reload the wait counter, go to DUMP_WAIT.
- reg_addr is 0 in HALTED/RUN/STEP. The core is frozen during DUMP, so captured values are coherent.
- cycle_cnt: +1 on every edge at which cpu_en=1; wraps modulo 2^CNT_W.

## Timing
- Command accepted at edge k: cpu_en and state reflect the new command from the cycle after edge k.
- RUN: cpu_en rises after edge k. HALT in RUN at edge k: cpu_en falls after edge k, so the core runs 0 extra cycles.
- STEP N at edge k: cpu_en=1 during cycles k+1..k+N. After edge k+N, cpu_en=0, halted=1 and cmd_ready=1, all together.
- DUMP at edge k: the first capture is at edge k+1+READ_LAT, and dump_valid=1 from that cycle.
  - With dump_ready tied high, words arrive every READ_LAT+2 cycles.
  - After the last handshake, halted=1 in the next cycle.
- Back-to-back commands: cmd_ready is combinational from state, so a new command may be accepted on the first cycle of HALTED.

## Test plan
- Reset held 22 time units while cmd_valid=1, op RUN -> during reset cpu_en=0 and halted=1; after release, RUN is accepted on the first edge and cpu_en=1 on the next cycle.
- STEP N=5 from HALTED -> cpu_en high for exactly 5 cycles and cycle_cnt +5. STEP N=0 -> cpu_en never rises and cycle_cnt unchanged.
- RUN, then DUMP after 10 cycles -> treated as HALT: cpu_en falls the next cycle, cycle_cnt=10, no dump_valid ever.
- DUMP with REG_COUNT=32, READ_LAT=0, dump_ready=1, core registers preloaded with r[i]=i*3 -> 32 words, dump_addr 0..31, dump_data=i*3, one word every 2 cycles, then halted=1.
- DUMP with READ_LAT=2 and random dump_ready stalls -> each word is held stable while not ready; no word is lost or duplicated; order is 0..31.
- rst_p asserted mid-DUMP at word 7 and mid-STEP N=100 -> all outputs return to reset values immediately, and after release the block is HALTED with cmd_ready=1.
